// File: rtl/reg_bank_issue_ctrl.sv
// Single-issue sequencer: accepts instruction words, reads the register bank,
// hands operands to the ALU and writes the result (or immediate) back.
module reg_bank_issue_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr_in,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [3:0]       source_1_sel,
   output logic [3:0]       source_2_sel,
   input  logic [31:0]      source_1,
   input  logic [31:0]      source_2,
   output logic [3:0]       destination,
   output logic [31:0]      LDR_mux,
   output logic             ldr_valid,
   output logic             alu_valid,
   input  logic             alu_ready,
   output logic [31:0]      alu_op_a,
   output logic [31:0]      alu_op_b,
   output logic [3:0]       alu_func,
   input  logic [31:0]      alu_result,
   output logic             busy,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WB
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ALU = 4'h1;
   localparam logic [3:0] OP_LDI = 4'h2;

   state_t             r_state;
   state_t             w_next_state;

   logic [3:0]         r_src1_sel;
   logic [3:0]         r_src2_sel;
   logic [3:0]         r_dest;
   logic [3:0]         r_func;
   logic [31:0]        r_wdata;
   logic [31:0]        r_op_a;
   logic [31:0]        r_op_b;
   logic               r_illegal;
   logic [CNT_W-1:0]   r_retired;

   logic [3:0]         w_opcode;
   logic [3:0]         w_dest;
   logic [3:0]         w_src1;
   logic [3:0]         w_src2;
   logic [15:0]        w_imm;

   assign w_opcode = instr_in[31:28];
   assign w_dest   = instr_in[27:24];
   assign w_src1   = instr_in[23:20];
   assign w_src2   = instr_in[19:16];
   assign w_imm    = instr_in[15:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: the default first keeps this block purely combinational; a missing
   // branch would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (instr_valid) begin
               case (w_opcode)
                  OP_ALU:  w_next_state = ST_READ;
                  OP_LDI:  w_next_state = ST_WB;
                  default: w_next_state = ST_IDLE;
               endcase
            end
         end
         ST_READ: w_next_state = ST_EXEC;
         ST_EXEC: if (alu_ready) w_next_state = ST_WB;
         ST_WB:   w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_src1_sel <= '0;
         r_src2_sel <= '0;
         r_dest     <= '0;
         r_func     <= '0;
         r_wdata    <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_illegal  <= 1'b0;
         r_retired  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (instr_valid) begin
                  case (w_opcode)
                     OP_NOP: r_retired <= r_retired + 1'b1;
                     OP_ALU: begin
                        r_src1_sel <= w_src1;
                        r_src2_sel <= w_src2;
                        r_dest     <= w_dest;
                        r_func     <= w_imm[3:0];
                     end
                     OP_LDI: begin
                        r_dest  <= w_dest;
                        r_wdata <= {16'h0000, w_imm};
                     end
                     default: r_illegal <= 1'b1;
                  endcase
               end
            end
            ST_READ: begin
               r_op_a <= source_1;
               r_op_b <= source_2;
            end
            ST_EXEC: if (alu_ready) r_wdata <= alu_result;
            ST_WB:   r_retired <= r_retired + 1'b1;
            default: ;
         endcase
      end
   end

   // Handshake strobes come straight from the state register.
   assign instr_ready   = (r_state == ST_IDLE);
   assign busy          = (r_state != ST_IDLE);
   assign alu_valid     = (r_state == ST_EXEC);
   assign ldr_valid     = (r_state == ST_WB);

   assign source_1_sel  = r_src1_sel;
   assign source_2_sel  = r_src2_sel;
   assign destination   = r_dest;
   assign LDR_mux       = r_wdata;
   assign alu_op_a      = r_op_a;
   assign alu_op_b      = r_op_b;
   assign alu_func      = r_func;
   assign illegal_op    = r_illegal;
   assign retired_count = r_retired;

endmodule

// File: tb/tb_reg_bank_issue_ctrl.sv
// Directed bench for reg_bank_issue_ctrl with a behavioural register bank;
// the counter is built 4 bits wide so wrap-around is reachable.
module tb_reg_bank_issue_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      instr_in;
   logic             instr_valid;
   logic             instr_ready;
   logic [3:0]       source_1_sel;
   logic [3:0]       source_2_sel;
   logic [31:0]      source_1;
   logic [31:0]      source_2;
   logic [3:0]       destination;
   logic [31:0]      LDR_mux;
   logic             ldr_valid;
   logic             alu_valid;
   logic             alu_ready;
   logic [31:0]      alu_op_a;
   logic [31:0]      alu_op_b;
   logic [3:0]       alu_func;
   logic [31:0]      alu_result;
   logic             busy;
   logic             illegal_op;
   logic [CNT_W-1:0] retired_count;

   logic [31:0]      bank [16];
   int               write_cnt = 0;
   int               n_checks  = 0;
   int               n_errors  = 0;
   int               wc_before;

   always #5 clk = ~clk;

   reg_bank_issue_ctrl #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_in      (instr_in),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .source_1_sel  (source_1_sel),
      .source_2_sel  (source_2_sel),
      .source_1      (source_1),
      .source_2      (source_2),
      .destination   (destination),
      .LDR_mux       (LDR_mux),
      .ldr_valid     (ldr_valid),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_op_a      (alu_op_a),
      .alu_op_b      (alu_op_b),
      .alu_func      (alu_func),
      .alu_result    (alu_result),
      .busy          (busy),
      .illegal_op    (illegal_op),
      .retired_count (retired_count)
   );

   // Register bank: combinational read, write on the strobe edge.
   assign source_1 = bank[source_1_sel];
   assign source_2 = bank[source_2_sel];

   always @(posedge clk) begin
      if (ldr_valid) begin
         bank[destination] <= LDR_mux;
         write_cnt         <= write_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] word);
      instr_in    = word;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ctl"}, {59'd0, instr_ready, busy, ldr_valid, alu_valid, illegal_op}, 64'b10000);
      check({tag, "_sel"}, {48'd0, source_1_sel, source_2_sel, destination, alu_func}, 64'd0);
      check({tag, "_ldr"}, {32'd0, LDR_mux}, 64'd0);
      check({tag, "_ops"}, {alu_op_a, alu_op_b}, 64'd0);
      check({tag, "_ret"}, {60'd0, retired_count}, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) bank[i] = 32'hA000_0000 | 32'(i);
      rst         = 1'b1;
      instr_in    = '0;
      instr_valid = 1'b0;
      alu_ready   = 1'b0;
      alu_result  = '0;
      tick();
      tick();
      rst = 1'b0;
      check_reset_state("reset");

      // LDI r3 <- 0xBEEF
      issue(32'h2300_BEEF);
      check("ldi_wb", {ldr_valid, instr_ready, destination, LDR_mux}, {1'b1, 1'b0, 4'h3, 32'h0000_BEEF});
      tick();
      check("ldi_done", {ldr_valid, instr_ready, 4'(retired_count)}, {1'b0, 1'b1, 4'd1});
      check("ldi_bank", bank[3], 32'h0000_BEEF);

      // ALU r7 <- f2(r3, r5), ALU immediately ready
      alu_ready  = 1'b1;
      alu_result = 32'h1234_5678;
      issue(32'h1735_0002);
      check("alu_read", {busy, alu_valid, ldr_valid, source_1_sel, source_2_sel}, {1'b1, 1'b0, 1'b0, 4'h3, 4'h5});
      tick();
      check("alu_exec", {alu_valid, alu_func}, {1'b1, 4'h2});
      check("alu_ops", {alu_op_a, alu_op_b}, {32'h0000_BEEF, 32'hA000_0005});
      tick();
      check("alu_wb", {ldr_valid, alu_valid, destination, LDR_mux}, {1'b1, 1'b0, 4'h7, 32'h1234_5678});
      tick();
      check("alu_done", {ldr_valid, instr_ready, 4'(retired_count)}, {1'b0, 1'b1, 4'd2});
      check("alu_bank", bank[7], 32'h1234_5678);

      // ALU r4 <- f9(r7, r3) with the ALU stalling for 5 cycles
      alu_ready  = 1'b0;
      alu_result = 32'hCAFE_0001;
      issue(32'h1473_0009);
      tick();
      wc_before = write_cnt;
      for (int i = 0; i < 5; i++) begin
         check("stall_hold", {alu_valid, ldr_valid, alu_func, alu_op_a, alu_op_b},
               {1'b1, 1'b0, 4'h9, 32'h1234_5678, 32'h0000_BEEF});
         tick();
      end
      alu_ready = 1'b1;
      check("stall_last", {alu_valid, ldr_valid, alu_op_a, alu_op_b},
            {1'b1, 1'b0, 32'h1234_5678, 32'h0000_BEEF});
      check("stall_nowr", 64'(write_cnt), 64'(wc_before));
      tick();
      check("stall_wb", {ldr_valid, destination, LDR_mux}, {1'b1, 4'h4, 32'hCAFE_0001});
      tick();
      check("stall_done", {ldr_valid, 4'(retired_count)}, {1'b0, 4'd3});
      check("stall_1wr", 64'(write_cnt), 64'(wc_before + 1));

      // Illegal opcode, then two NOPs: flag sticks, nothing written
      wc_before = write_cnt;
      issue(32'hF000_0000);
      check("illegal", {illegal_op, instr_ready, ldr_valid, 4'(retired_count)}, {1'b1, 1'b1, 1'b0, 4'd3});
      issue(32'h0000_0000);
      issue(32'h0000_0000);
      check("illegal_sticky", {illegal_op, ldr_valid, 4'(retired_count)}, {1'b1, 1'b0, 4'd5});
      check("illegal_nowr", 64'(write_cnt), 64'(wc_before));

      // Reset while waiting in EXEC, with alu_ready also high on that edge
      alu_ready = 1'b0;
      issue(32'h1812_0001);
      tick();
      check("exec_reached", alu_valid, 1'b1);
      wc_before = write_cnt;
      rst       = 1'b1;
      alu_ready = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("rst_exec");
      tick();
      check("rst_exec_nowr", {63'd0, ldr_valid}, 64'd0);
      check("rst_exec_cnt", 64'(write_cnt), 64'(wc_before));

      // Reset during WB
      issue(32'h2900_1234);
      check("wb_reached", {ldr_valid, destination}, {1'b1, 4'h9});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("rst_wb");

      // A following LDI completes normally
      issue(32'h2900_5A5A);
      check("post_rst_wb", {ldr_valid, destination, LDR_mux}, {1'b1, 4'h9, 32'h0000_5A5A});
      tick();
      check("post_rst_done", {ldr_valid, instr_ready, 4'(retired_count)}, {1'b0, 1'b1, 4'd1});
      check("post_rst_bank", bank[9], 32'h0000_5A5A);

      // 17 back-to-back NOPs from a clean counter: wraps 15 -> 0 -> 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("nop_start", {60'd0, retired_count}, 64'd0);
      instr_in    = 32'h0000_0000;
      instr_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("nop_ready", {busy, instr_ready}, {1'b0, 1'b1});
      end
      check("nop_allones", {60'd0, retired_count}, 64'd15);
      tick();
      check("nop_wrap0", {60'd0, retired_count}, 64'd0);
      tick();
      instr_valid = 1'b0;
      check("nop_wrap1", {60'd0, retired_count}, 64'd1);
      tick();
      check("nop_idle", {60'd0, retired_count}, 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
